// File: rtl/mysoc_sysid_checker.sv
// Avalon-MM read master that fetches the system-ID and build timestamp words
// and compares them against the expected build constants, with per-word timeout/retry.
module mysoc_sysid_checker #(
  parameter logic [31:0] EXPECTED_ID        = 32'd0,
  parameter logic [31:0] EXPECTED_TIMESTAMP = 32'd1648042550,
  parameter int unsigned TIMEOUT_CYCLES     = 255,
  parameter int unsigned MAX_RETRIES        = 3
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  output logic        address,
  output logic        read,
  input  logic [31:0] readdata,
  input  logic        waitrequest,
  input  logic        readdatavalid,
  output logic        busy,
  output logic        done,
  output logic        id_ok,
  output logic        ts_ok,
  output logic        timed_out,
  output logic [31:0] id_value,
  output logic [31:0] ts_value
);

  localparam int unsigned TCNT_W  = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam int unsigned RETRY_W = 4;

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] ID_CMD = 3'd1;
  localparam logic [2:0] ID_RSP = 3'd2;
  localparam logic [2:0] TS_CMD = 3'd3;
  localparam logic [2:0] TS_RSP = 3'd4;
  localparam logic [2:0] FIN    = 3'd5;

  logic [2:0]         state_q, state_d;
  logic [TCNT_W-1:0]  tcnt_q, tcnt_d;
  logic [RETRY_W-1:0] retry_q, retry_d;
  logic               address_d, read_d, busy_d, done_d;
  logic               id_ok_d, ts_ok_d, timed_out_d;
  logic [31:0]        id_value_d, ts_value_d;

  logic attempt_to_c;
  logic retries_spent_c;
  logic [TCNT_W-1:0] tcnt_inc_c;

  assign attempt_to_c    = (tcnt_q == TCNT_W'(TIMEOUT_CYCLES - 1));
  assign retries_spent_c = (retry_q == RETRY_W'(MAX_RETRIES));
  // Saturates so an accept on the last cycle still leaves one cycle for the response.
  assign tcnt_inc_c      = attempt_to_c ? tcnt_q : tcnt_q + TCNT_W'(1);

  // Register update
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= IDLE;
      tcnt_q    <= '0;
      retry_q   <= '0;
      address   <= 1'b0;
      read      <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      id_ok     <= 1'b0;
      ts_ok     <= 1'b0;
      timed_out <= 1'b0;
      id_value  <= '0;
      ts_value  <= '0;
    end else begin
      state_q   <= state_d;
      tcnt_q    <= tcnt_d;
      retry_q   <= retry_d;
      address   <= address_d;
      read      <= read_d;
      busy      <= busy_d;
      done      <= done_d;
      id_ok     <= id_ok_d;
      ts_ok     <= ts_ok_d;
      timed_out <= timed_out_d;
      id_value  <= id_value_d;
      ts_value  <= ts_value_d;
    end
  end

  // Next-state and next-output logic
  always_comb begin
    state_d     = state_q;
    tcnt_d      = tcnt_q;
    retry_d     = retry_q;
    address_d   = address;
    read_d      = read;
    busy_d      = busy;
    done_d      = 1'b0;
    id_ok_d     = id_ok;
    ts_ok_d     = ts_ok;
    timed_out_d = timed_out;
    id_value_d  = id_value;
    ts_value_d  = ts_value;

    case (state_q)
      IDLE: begin
        if (start) begin
          state_d     = ID_CMD;
          busy_d      = 1'b1;
          id_ok_d     = 1'b0;
          ts_ok_d     = 1'b0;
          timed_out_d = 1'b0;
          retry_d     = '0;
          tcnt_d      = '0;
          read_d      = 1'b1;
          address_d   = 1'b0;
        end
      end

      ID_CMD, TS_CMD: begin
        tcnt_d = tcnt_inc_c;
        if (read && !waitrequest) begin
          read_d  = 1'b0;
          state_d = (state_q == ID_CMD) ? ID_RSP : TS_RSP;
        end else if (attempt_to_c) begin
          read_d = 1'b0;
          if (retries_spent_c) begin
            timed_out_d = 1'b1;
            ts_ok_d     = 1'b0;
            if (state_q == ID_CMD) id_ok_d = 1'b0;
            state_d = FIN;
          end else begin
            retry_d = retry_q + RETRY_W'(1);
            tcnt_d  = '0;
          end
        end else if (!read) begin
          // First cycle of a retry re-issues the strobe
          read_d = 1'b1;
        end
      end

      ID_RSP, TS_RSP: begin
        tcnt_d = tcnt_inc_c;
        if (readdatavalid) begin
          if (state_q == ID_RSP) begin
            id_value_d = readdata;
            id_ok_d    = (readdata == EXPECTED_ID);
            state_d    = TS_CMD;
            read_d     = 1'b1;
            address_d  = 1'b1;
            tcnt_d     = '0;
            retry_d    = '0;
          end else begin
            ts_value_d = readdata;
            ts_ok_d    = (readdata == EXPECTED_TIMESTAMP);
            state_d    = FIN;
          end
        end else if (attempt_to_c) begin
          if (retries_spent_c) begin
            timed_out_d = 1'b1;
            ts_ok_d     = 1'b0;
            if (state_q == ID_RSP) id_ok_d = 1'b0;
            state_d = FIN;
          end else begin
            retry_d = retry_q + RETRY_W'(1);
            tcnt_d  = '0;
            state_d = (state_q == ID_RSP) ? ID_CMD : TS_CMD;
          end
        end
      end

      FIN: begin
        done_d  = 1'b1;
        busy_d  = 1'b0;
        read_d  = 1'b0;
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
        read_d  = 1'b0;
        busy_d  = 1'b0;
      end
    endcase
  end

endmodule
